regfile_writeback_queue: RTL and testbench

Write-side companion to the 16×8 register file: buffers results retired from the execute stage and drives the register file's single write port (`n_w`, `rd`, `data_in`), one write per cycle. It also forwards pending (queued, not yet written) values onto the rs/rt read paths, so reads always return the architecturally newest value. It sits between execute/writeback logic and the register file and is the only block that drives the register file write port.

---
 rtl/regfile_writeback_queue.sv | 114 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - writeback FIFO driving the register file write port
// Forwards queued (not yet written) values onto the rs/rt read paths.
module regfile_writeback_queue #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              drain_hold,
  output logic              rf_n_w,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [ADDR_W-1:0] rd_mem_d   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign wb_ready = !full;
  assign rf_n_w   = !(!empty && !drain_hold);
  assign rf_rd      = empty ? '0 : rd_mem_q[head_q];
  assign rf_data_in = empty ? '0 : data_mem_q[head_q];

  // Writes to r0 complete the handshake but are dropped.
  assign push = wb_valid && wb_ready && (wb_rd != '0);
  assign pop  = !rf_n_w;

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (push) begin
      rd_mem_d[tail_q]   = wb_rd;
      data_mem_d[tail_q] = wb_data;
      tail_d             = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  // Walk oldest to youngest so the last match wins.
  function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] raw);
    logic [DATA_W-1:0] v;
    logic [PTR_W-1:0]  idx;
    v = raw;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (rd_mem_q[idx] == a)) begin
        v = data_mem_q[idx];
      end
    end
    if (a == '0) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    rs_data = fwd(rs, rf_rs_data);
    rt_data = fwd(rt, rf_rt_data);
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - scoreboard bench for regfile_writeback_queue
module tb_regfile_writeback_queue;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       wb_valid;
  logic [3:0] wb_rd;
  logic [7:0] wb_data;
  logic       wb_ready;
  logic       drain_hold;
  logic       rf_n_w;
  logic [3:0] rf_rd;
  logic [7:0] rf_data_in;
  logic [3:0] rs, rt;
  logic [7:0] rf_rs_data, rf_rt_data;
  logic [7:0] rs_data, rt_data;
  logic [2:0] count;
  logic       empty, full;

  typedef struct {
    logic [3:0] rd;
    logic [7:0] data;
  } ent_t;

  ent_t sb[$];
  int   tests  = 0;
  int   fails  = 0;
  int   writes = 0;
  int   wsnap;
  logic rf_force = 1'b0;
  logic [7:0] rf_mem [16] = '{default: 8'h00};

  regfile_writeback_queue dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .drain_hold (drain_hold),
    .rf_n_w     (rf_n_w),
    .rf_rd      (rf_rd),
    .rf_data_in (rf_data_in),
    .rs         (rs),
    .rt         (rt),
    .rf_rs_data (rf_rs_data),
    .rf_rt_data (rf_rt_data),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rf_n_w) rf_mem[rf_rd] <= rf_data_in;
  end

  assign rf_rs_data = rf_force ? 8'hFF : rf_mem[rs];
  assign rf_rt_data = rf_force ? 8'hFF : rf_mem[rt];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] rd, input logic [7:0] d);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic drain_wait();
    for (int k = 0; k < 20 && !empty; k++) tick();
    chk("drain_done", {31'd0, empty}, 32'd1);
  endtask

  // Inputs only change just after a rising edge, so the falling edge sees what the next edge commits.
  always @(negedge clk) begin
    ent_t e;
    if (!n_reset) begin
      sb.delete();
      chk("no_write_in_reset", {31'd0, rf_n_w}, 32'd1);
    end else begin
      if (!rf_n_w) begin
        writes++;
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL wr_unexpected observed=write rd=%0h expected=no write", rf_rd);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_rd", {28'd0, rf_rd}, {28'd0, e.rd});
          chk("wr_data", {24'd0, rf_data_in}, {24'd0, e.data});
        end
      end
      if (wb_valid && wb_ready && wb_rd != 4'd0) begin
        e.rd   = wb_rd;
        e.data = wb_data;
        sb.push_back(e);
      end
    end
  end

  initial begin
    n_reset = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    drain_hold = 1'b0; rs = '0; rt = '0;
    tick(); tick();
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ready", {31'd0, wb_ready}, 32'd1);
    chk("rst_n_w", {31'd0, rf_n_w}, 32'd1);
    chk("rst_rf_rd", {28'd0, rf_rd}, 32'd0);
    chk("rst_rf_data", {24'd0, rf_data_in}, 32'd0);
    n_reset = 1'b1;
    tick();

    // single push, one-cycle latency to the write port
    rs = 4'd3;
    offer(4'd3, 8'h5A);
    chk("p1_n_w", {31'd0, rf_n_w}, 32'd0);
    chk("p1_rd", {28'd0, rf_rd}, 32'd3);
    chk("p1_data", {24'd0, rf_data_in}, 32'h5A);
    chk("p1_count", {29'd0, count}, 32'd1);
    chk("p1_fwd", {24'd0, rs_data}, 32'h5A);
    tick();
    chk("p1_empty", {31'd0, empty}, 32'd1);
    chk("p1_rf_rs", {24'd0, rs_data}, 32'h5A);

    // forwarding picks the youngest duplicate
    drain_hold = 1'b1;
    rs = 4'd5; rt = 4'd5;
    offer(4'd5, 8'h11);
    offer(4'd5, 8'h22);
    chk("fw_rs", {24'd0, rs_data}, 32'h22);
    chk("fw_rt", {24'd0, rt_data}, 32'h22);
    chk("fw_hold_n_w", {31'd0, rf_n_w}, 32'd1);
    chk("fw_count", {29'd0, count}, 32'd2);
    drain_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fw_track", {24'd0, rs_data}, 32'h22);
    end
    chk("fw_empty", {31'd0, empty}, 32'd1);

    // full, rejected offer, then wrap under continuous pushes
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) offer(4'(i + 1), 8'hA0 + 8'(i));
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_ready", {31'd0, wb_ready}, 32'd0);
    offer(4'd6, 8'hBB);
    chk("full_count", {29'd0, count}, 32'd4);
    drain_hold = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wb_valid = 1'b1;
      wb_rd    = 4'((i % 7) + 1);
      wb_data  = 8'hC0 + 8'(i);
      tick();
    end
    wb_valid = 1'b0;
    drain_wait();
    chk("wrap_sb_empty", sb.size(), 32'd0);

    // register 0 is never queued or written
    drain_hold = 1'b1;
    offer(4'd7, 8'h77);
    offer(4'd0, 8'hFF);
    chk("r0_count", {29'd0, count}, 32'd1);
    wsnap = writes;
    drain_hold = 1'b0;
    drain_wait();
    chk("r0_writes", writes - wsnap, 32'd1);
    rf_force = 1'b1; rs = 4'd0; rt = 4'd0;
    #1;
    chk("r0_rs", {24'd0, rs_data}, 32'd0);
    chk("r0_rt", {24'd0, rt_data}, 32'd0);
    rs = 4'd9;
    #1;
    chk("raw_rs", {24'd0, rs_data}, 32'hFF);
    rf_force = 1'b0;

    // simultaneous push and pop at count 2
    drain_hold = 1'b1;
    offer(4'd8, 8'h81);
    offer(4'd9, 8'h92);
    drain_hold = 1'b0;
    offer(4'd10, 8'hA3);
    chk("sim_count1", {29'd0, count}, 32'd2);
    offer(4'd11, 8'hB4);
    chk("sim_count2", {29'd0, count}, 32'd2);
    drain_wait();
    chk("sim_sb_empty", sb.size(), 32'd0);

    // asynchronous reset with entries pending
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) offer(4'd12, 8'hD0 + 8'(i));
    drain_hold = 1'b0;
    tick();
    chk("mid_count_pre", {29'd0, count}, 32'd3);
    n_reset = 1'b0;
    #1;
    chk("mid_count", {29'd0, count}, 32'd0);
    chk("mid_n_w", {31'd0, rf_n_w}, 32'd1);
    tick(); tick();
    wsnap = writes;
    n_reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_no_writes", writes - wsnap, 32'd0);
    chk("mid_empty", {31'd0, empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
